// File: rtl/router_pkg.sv
// Shared defaults and header helpers for the router output FIFO.
// Header word layout: {payload_len[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}.
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;
    localparam int DEPTH_DEF  = 16;
    localparam int PTR_W      = $clog2(DEPTH_DEF) + 1;

    // Payload length carried in a header word (address field shifted out).
    function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_w);
        return hdr >> addr_w;
    endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Simple dual-port storage for the packet FIFO.
// Ports:
//   i_clock  - write clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write word ({marker, data})
//   i_raddr  - read address
//   o_rdata  - combinational read word
module router_fifo_ram
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF + 1,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO, one per router destination port.
// Each stored word carries a header-marker bit; write and read sides track
// packet boundaries so complete packets can be counted and sop/eop flagged.
// Ports:
//   i_clock, i_reset (async, active-high), i_soft_reset (sync flush)
//   i_write_enb, i_lfd_state (header marker), i_data_in  - write side
//   i_read_enb, o_data_out, o_sop_out, o_eop_out         - read side (registered)
//   o_empty, o_full, o_almost_full, o_level               - occupancy
//   o_pkt_count                                           - complete packets stored
//   o_err_ovf, o_err_udf                                  - sticky error flags
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AF_THR = DEPTH - 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_soft_reset,
    input  logic                     i_write_enb,
    input  logic                     i_lfd_state,
    input  logic [DATA_W-1:0]        i_data_in,
    input  logic                     i_read_enb,
    output logic [DATA_W-1:0]        o_data_out,
    output logic                     o_sop_out,
    output logic                     o_eop_out,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_almost_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [$clog2(DEPTH):0]   o_pkt_count,
    output logic                     o_err_ovf,
    output logic                     o_err_udf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [LVL_W-1:0]  r_wr_ptr;
    logic [LVL_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_wcnt;
    logic [DATA_W-1:0] r_rcnt;
    logic [LVL_W-1:0]  r_pkt_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_sop;
    logic              r_eop;
    logic              r_ovf;
    logic              r_udf;

    logic [LVL_W-1:0]  w_level;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W:0]   w_rd_word;
    logic              w_rd_marker;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_wr_len;
    logic [DATA_W-1:0] w_rd_len;
    logic              w_pkt_inc;
    logic              w_pkt_dec;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_wr_acc = i_write_enb && !w_full;
    assign w_rd_acc = i_read_enb && !w_empty;

    router_fifo_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clock (i_clock),
        .i_we    (w_wr_acc && !i_soft_reset),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({i_lfd_state, i_data_in}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_word)
    );

    assign w_rd_marker = w_rd_word[DATA_W];
    assign w_rd_data   = w_rd_word[DATA_W-1:0];

    // Packet span = payload words + parity word.
    assign w_wr_len = DATA_W'(hdr_len(32'(i_data_in), ADDR_W) + 32'd1);
    assign w_rd_len = DATA_W'(hdr_len(32'(w_rd_data), ADDR_W) + 32'd1);

    assign w_pkt_inc = w_wr_acc && !i_lfd_state && (r_wcnt == DATA_W'(1));
    assign w_pkt_dec = w_rd_acc && !w_rd_marker && (r_rcnt == DATA_W'(1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_pkt_count <= '0;
            r_data_out  <= '0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else if (i_soft_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_pkt_count <= '0;
            r_data_out  <= '0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                // A marker always reloads, dropping any truncated packet.
                if (i_lfd_state) begin
                    r_wcnt <= w_wr_len;
                end else if (r_wcnt != '0) begin
                    r_wcnt <= r_wcnt - 1'b1;
                end
            end

            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= w_rd_data;
                r_sop      <= w_rd_marker;
                r_eop      <= w_pkt_dec;
                if (w_rd_marker) begin
                    r_rcnt <= w_rd_len;
                end else if (r_rcnt != '0) begin
                    r_rcnt <= r_rcnt - 1'b1;
                end
            end else if (r_rcnt == '0) begin
                // Outside a packet the output bus idles at zero.
                r_data_out <= '0;
                r_sop      <= 1'b0;
                r_eop      <= 1'b0;
            end

            if (w_pkt_inc && !w_pkt_dec) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end else if (w_pkt_dec && !w_pkt_inc) begin
                r_pkt_count <= r_pkt_count - 1'b1;
            end

            if (i_write_enb && w_full) begin
                r_ovf <= 1'b1;
            end
            if (i_read_enb && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o_data_out    = r_data_out;
    assign o_sop_out     = r_sop;
    assign o_eop_out     = r_eop;
    assign o_empty       = w_empty;
    assign o_full        = w_full;
    assign o_almost_full = (w_level >= LVL_W'(AF_THR));
    assign o_level       = w_level;
    assign o_pkt_count   = r_pkt_count;
    assign o_err_ovf     = r_ovf;
    assign o_err_udf     = r_udf;

endmodule
